// File: rtl/appliance_pkg.sv
// -----------------------------------------------------------------------------
// appliance_pkg
// Shared appliance definitions used by the washer cycle sequencer and its
// phase timer: the phase encoding visible on the phase output, counter widths,
// the fixed drain duration used after an abort, and helpers that walk the
// phase order FILL -> WASH -> RINSE -> SPIN while skipping zero-length phases.
// No ports (package).
// -----------------------------------------------------------------------------
package appliance_pkg;

  localparam int DUR_W = 5;  // width of one phase duration
  localparam int REM_W = 8;  // width of the whole-cycle remaining count

  // Encoding is externally visible on the phase output.
  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4,
    PH_DRAIN = 3'd5
  } phase_e;

  localparam logic [DUR_W-1:0] DRAIN_TICKS = 5'd2;

  // FILL uses the cloth duration.
  typedef struct packed {
    logic [DUR_W-1:0] cloth;
    logic [DUR_W-1:0] wash;
    logic [DUR_W-1:0] rinse;
    logic [DUR_W-1:0] spin;
  } durations_t;

  // First phase after 'cur' (in the normal order) whose duration is nonzero.
  // Returns PH_IDLE when nothing is left, which marks the end of the cycle.
  function automatic phase_e next_active(phase_e cur, durations_t d);
    logic fill_ok;
    logic wash_ok;
    logic rinse_ok;
    logic spin_ok;
    fill_ok  = (cur == PH_IDLE) && (d.cloth != '0);
    wash_ok  = (cur inside {PH_IDLE, PH_FILL}) && (d.wash != '0);
    rinse_ok = (cur inside {PH_IDLE, PH_FILL, PH_WASH}) && (d.rinse != '0);
    spin_ok  = (cur inside {PH_IDLE, PH_FILL, PH_WASH, PH_RINSE}) && (d.spin != '0);
    if (fill_ok)       return PH_FILL;
    else if (wash_ok)  return PH_WASH;
    else if (rinse_ok) return PH_RINSE;
    else if (spin_ok)  return PH_SPIN;
    else               return PH_IDLE;
  endfunction

  function automatic logic [DUR_W-1:0] duration_of(phase_e ph, durations_t d);
    case (ph)
      PH_FILL:  return d.cloth;
      PH_WASH:  return d.wash;
      PH_RINSE: return d.rinse;
      PH_SPIN:  return d.spin;
      PH_DRAIN: return DRAIN_TICKS;
      default:  return '0;
    endcase
  endfunction

  // Four 5-bit values sum to at most 124, so 8 bits never overflow.
  function automatic logic [REM_W-1:0] sum_durations(durations_t d);
    return REM_W'(d.cloth) + REM_W'(d.wash) + REM_W'(d.rinse) + REM_W'(d.spin);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Loadable down-counter holding the ticks left in the current phase.
// Load has priority over decrement; the counter never wraps below zero.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   load_i        load load_val_i on the next edge
//   load_val_i    value to load
//   tick_en_i     decrement by one on the next edge (when not loading)
//   count_o       current count
//   zero_o        count is zero
// -----------------------------------------------------------------------------
module phase_timer
  import appliance_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [DUR_W-1:0] load_val_i,
  input  logic             tick_en_i,
  output logic [DUR_W-1:0] count_o,
  output logic             zero_o
);

  logic [DUR_W-1:0] count_q;
  logic [DUR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/washer_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// washer_cycle_sequencer
// Runs one washing cycle FILL -> WASH -> RINSE -> SPIN from four latched
// durations (in time-base ticks), skipping zero-length phases, with pause and
// abort. Abort diverts into a fixed-length DRAIN and returns to IDLE without
// the completion pulse.
//
// Optional feature: define WASHER_DOOR_LOCK_EN to add the door interlock
// (door_closed input, door_lock output). Without it those ports do not exist.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   wash_in, rinse_in, spin_in,
//   cloth_in [4:0]                      phase durations (cloth_in -> FILL)
//   tick                                one-cycle time-base strobe
//   start, pause, abort                 level-sampled commands
//   door_closed (option)                door sensor; open while busy = pause
//   phase [2:0]                         current phase (appliance_pkg encoding)
//   remaining [7:0]                     ticks left in the whole cycle
//   water_valve, motor_on, drain_pump   actuator drives
//   busy                                any phase other than IDLE
//   door_lock (option)                  equals busy
//   done                                one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module washer_cycle_sequencer
  import appliance_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DUR_W-1:0] wash_in,
  input  logic [DUR_W-1:0] rinse_in,
  input  logic [DUR_W-1:0] spin_in,
  input  logic [DUR_W-1:0] cloth_in,
  input  logic             tick,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
`ifdef WASHER_DOOR_LOCK_EN
  input  logic             door_closed,
  output logic             door_lock,
`endif
  output logic [2:0]       phase,
  output logic [REM_W-1:0] remaining,
  output logic             water_valve,
  output logic             motor_on,
  output logic             drain_pump,
  output logic             busy,
  output logic             done
);

  phase_e           phase_q;
  phase_e           phase_d;
  logic [REM_W-1:0] remaining_q;
  logic [REM_W-1:0] remaining_d;
  durations_t       dur_q;
  durations_t       dur_d;
  logic             done_q;
  logic             done_d;

  durations_t       dur_in;
  phase_e           target_ph;
  logic             busy_w;
  logic             hold;
  logic             start_ok;
  logic             last_tick;

  logic             tmr_load;
  logic [DUR_W-1:0] tmr_val;
  logic             tmr_en;
  logic [DUR_W-1:0] tmr_count;
  logic             tmr_zero;

  assign dur_in = '{cloth: cloth_in, wash: wash_in, rinse: rinse_in, spin: spin_in};
  assign busy_w = (phase_q != PH_IDLE);

`ifdef WASHER_DOOR_LOCK_EN
  // An open door during a cycle behaves exactly like pause.
  assign hold      = pause | (busy_w & ~door_closed);
  assign start_ok  = start & door_closed;
  assign door_lock = busy_w;
`else
  assign hold      = pause;
  assign start_ok  = start;
`endif

  // The tick that takes the phase counter from 1 to 0 is the one that moves
  // the sequencer on; the zero check only guards against a stale counter.
  assign last_tick = tmr_zero || (tmr_count == 5'd1);

  phase_timer u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tick_en_i  (tmr_en),
    .count_o    (tmr_count),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    phase_d     = phase_q;
    remaining_d = remaining_q;
    dur_d       = dur_q;
    done_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_en      = 1'b0;
    target_ph   = PH_IDLE;

    unique case (phase_q)
      PH_IDLE: begin
        // Start uses the live inputs; the latched copy is only valid from the
        // next cycle on.
        if (start_ok && !abort && (dur_in != '0)) begin
          target_ph   = next_active(PH_IDLE, dur_in);
          dur_d       = dur_in;
          phase_d     = target_ph;
          remaining_d = sum_durations(dur_in);
          tmr_load    = 1'b1;
          tmr_val     = duration_of(target_ph, dur_in);
        end
      end

      PH_DRAIN: begin
        // Drain ignores both pause and abort.
        if (tick) begin
          remaining_d = remaining_q - 1'b1;
          if (last_tick) begin
            phase_d     = PH_IDLE;
            remaining_d = '0;
            tmr_load    = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end
      end

      default: begin
        if (abort) begin
          phase_d     = PH_DRAIN;
          remaining_d = REM_W'(DRAIN_TICKS);
          tmr_load    = 1'b1;
          tmr_val     = DRAIN_TICKS;
        end else if (!hold && tick) begin
          remaining_d = remaining_q - 1'b1;
          if (last_tick) begin
            target_ph = next_active(phase_q, dur_q);
            phase_d   = target_ph;
            tmr_load  = 1'b1;
            tmr_val   = duration_of(target_ph, dur_q);
            // Running out of phases is the normal end of the cycle.
            if (target_ph == PH_IDLE) begin
              done_d      = 1'b1;
              remaining_d = '0;
            end
          end else begin
            tmr_en = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= PH_IDLE;
      remaining_q <= '0;
      dur_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      dur_q       <= dur_d;
      done_q      <= done_d;
    end
  end

  // Outputs decode straight from the registers, so an asserted reset clears
  // them at once without a clock edge.
  assign phase       = phase_q;
  assign remaining   = remaining_q;
  assign busy        = busy_w;
  assign done        = done_q;
  assign water_valve = ((phase_q == PH_FILL) || (phase_q == PH_RINSE)) && !hold;
  assign motor_on    = ((phase_q == PH_WASH) || (phase_q == PH_RINSE) ||
                        (phase_q == PH_SPIN)) && !hold;
  assign drain_pump  = (phase_q == PH_SPIN) || (phase_q == PH_DRAIN);

endmodule

// File: tb/tb_washer_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for washer_cycle_sequencer (default build, no door interlock).
// A reference model keeps the cycle as a queue of (phase, duration) segments
// built from the nonzero durations and is stepped once per clock from the
// same inputs the DUT sees; all outputs are compared every cycle.
// -----------------------------------------------------------------------------
module tb_washer_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] wash_in = '0;
  logic [4:0] rinse_in = '0;
  logic [4:0] spin_in = '0;
  logic [4:0] cloth_in = '0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] phase;
  logic [7:0] remaining;
  logic       water_valve;
  logic       motor_on;
  logic       drain_pump;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  washer_cycle_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wash_in     (wash_in),
    .rinse_in    (rinse_in),
    .spin_in     (spin_in),
    .cloth_in    (cloth_in),
    .tick        (tick),
    .start       (start),
    .pause       (pause),
    .abort       (abort),
    .phase       (phase),
    .remaining   (remaining),
    .water_valve (water_valve),
    .motor_on    (motor_on),
    .drain_pump  (drain_pump),
    .busy        (busy),
    .done        (done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int ph;
    int dur;
  } seg_t;

  seg_t m_pend[$];
  int   m_ph   = 0;   // 0 idle, 1 fill, 2 wash, 3 rinse, 4 spin, 5 drain
  int   m_left = 0;
  int   m_rem  = 0;
  bit   m_done = 0;
  int   done_seen  = 0;
  int   phase_mask = 0;

  task automatic model_reset();
    m_pend.delete();
    m_ph = 0; m_left = 0; m_rem = 0; m_done = 0;
  endtask

  task automatic model_step();
    seg_t s;
    int   tot;
    m_done = 0;
    if (m_ph == 0) begin
      tot = int'(cloth_in) + int'(wash_in) + int'(rinse_in) + int'(spin_in);
      if (start && !abort && tot > 0) begin
        m_pend.delete();
        if (cloth_in != 0) m_pend.push_back('{1, int'(cloth_in)});
        if (wash_in  != 0) m_pend.push_back('{2, int'(wash_in)});
        if (rinse_in != 0) m_pend.push_back('{3, int'(rinse_in)});
        if (spin_in  != 0) m_pend.push_back('{4, int'(spin_in)});
        s = m_pend.pop_front();
        m_ph = s.ph; m_left = s.dur; m_rem = tot;
      end
    end else if (m_ph == 5) begin
      if (tick) begin
        m_left--; m_rem--;
        if (m_left == 0) begin m_ph = 0; m_rem = 0; end
      end
    end else if (abort) begin
      m_pend.delete();
      m_ph = 5; m_left = 2; m_rem = 2;
    end else if (!pause && tick) begin
      m_left--; m_rem--;
      if (m_left == 0) begin
        if (m_pend.size() == 0) begin
          m_ph = 0; m_done = 1;
        end else begin
          s = m_pend.pop_front();
          m_ph = s.ph; m_left = s.dur;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    check("phase", int'(phase), m_ph);
    check("remaining", int'(remaining), m_rem);
    check("water_valve", int'(water_valve), int'((m_ph == 1 || m_ph == 3) && !pause));
    check("motor_on", int'(motor_on), int'((m_ph >= 2 && m_ph <= 4) && !pause));
    check("drain_pump", int'(drain_pump), int'(m_ph == 4 || m_ph == 5));
    check("busy", int'(busy), int'(m_ph != 0));
    check("done", int'(done), int'(m_done));
    if (done) done_seen++;
    phase_mask = phase_mask | (1 << phase);
  endtask

  // Called at edge+1 with inputs already set: compare at edge+2, then step.
  task automatic cycle();
    #1;
    compare_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit st, input bit pa, input bit ab, input bit tk);
    start = st; pause = pa; abort = ab; tick = tk;
    cycle();
  endtask

  task automatic set_durations(input int c, input int w, input int r, input int s);
    cloth_in = 5'(c); wash_in = 5'(w); rinse_in = 5'(r); spin_in = 5'(s);
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (m_ph != 0 && n < budget) begin
      drive(0, 0, 0, (n % 3) == 0);
      n++;
    end
    drive(0, 0, 0, 0);
    check({tag, "_within_budget"}, int'(n < budget), 1);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  int snap;

  initial begin
    // ---------------- reset ----------------
    #2;
    model_reset();
    compare_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 1);
    $display("txn reset: outputs idle after reset");

    // ---------------- full cycle 2/7/13/12 ----------------
    set_durations(2, 7, 13, 12);
    done_seen = 0;
    drive(1, 0, 0, 0);
    check("full_first_phase", int'(phase), 1);
    check("full_remaining", int'(remaining), 34);
    run_until_idle("full", 400);
    check("full_done_count", done_seen, 1);
    $display("txn full_cycle: cloth=2 wash=7 rinse=13 spin=12 done_pulses=%0d", done_seen);

    // ---------------- rinse only ----------------
    set_durations(0, 0, 3, 0);
    done_seen = 0; phase_mask = 0;
    drive(1, 0, 0, 0);
    check("rinse_only_phase", int'(phase), 3);
    run_until_idle("rinse_only", 100);
    check("rinse_only_phases_seen", phase_mask, 9);
    check("rinse_only_done_count", done_seen, 1);
    $display("txn rinse_only: phase_mask=%0d done_pulses=%0d", phase_mask, done_seen);

    // ---------------- all zero start ----------------
    set_durations(0, 0, 0, 0);
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 0);
    check("zero_start_phase", int'(phase), 0);
    check("zero_start_busy", int'(busy), 0);
    $display("txn zero_start: phase=%0d busy=%0d", phase, busy);

    // ---------------- pause mid-WASH ----------------
    set_durations(0, 10, 0, 1);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
    snap = int'(remaining);
    for (int i = 0; i < 10; i++) drive(0, 1, 0, (i % 2) == 0);
    check("pause_remaining_frozen", int'(remaining), snap);
    check("pause_motor_off", int'(motor_on), 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    check("pause_resume", int'(remaining), snap - 1);
    run_until_idle("pause", 100);
    $display("txn pause_wash: frozen_at=%0d", snap);

    // ---------------- abort in RINSE ----------------
    set_durations(0, 0, 6, 3);
    done_seen = 0;
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(1, 0, 1, 0);
    check("abort_phase", int'(phase), 5);
    check("abort_pump", int'(drain_pump), 1);
    check("abort_remaining", int'(remaining), 2);
    run_until_idle("abort", 50);
    check("abort_no_done", done_seen, 0);
    $display("txn abort_rinse: done_pulses=%0d", done_seen);

    // ---------------- randomized cycles ----------------
    for (int sc = 0; sc < 30; sc++) begin
      int n;
      set_durations(($urandom_range(3, 0) == 0) ? 0 : $urandom_range(31, 1),
                    ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(31, 1),
                    ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(31, 1),
                    ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(31, 1));
      done_seen = 0;
      drive(1, 0, 0, $urandom_range(1, 0) == 1);
      n = 0;
      while (m_ph != 0 && n < 1500) begin
        if ($urandom_range(15, 0) == 0)
          set_durations($urandom_range(31, 0), $urandom_range(31, 0),
                        $urandom_range(31, 0), $urandom_range(31, 0));
        drive($urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0,
              $urandom_range(299, 0) == 0, $urandom_range(1, 0) == 1);
        n++;
      end
      drive(0, 0, 0, 0);
      check("random_within_budget", int'(n < 1500), 1);
      $display("txn random %0d: cycles=%0d done_pulses=%0d", sc, n, done_seen);
    end

    // ---------------- reset mid-SPIN ----------------
    set_durations(0, 0, 0, 20);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
    check("spin_before_reset", int'(phase), 4);
    rst_n = 1'b0;
    #1;
    check("rst_phase", int'(phase), 0);
    check("rst_remaining", int'(remaining), 0);
    check("rst_water_valve", int'(water_valve), 0);
    check("rst_motor_on", int'(motor_on), 0);
    check("rst_drain_pump", int'(drain_pump), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
    $display("txn reset_mid_spin: phase=%0d busy=%0d", phase, busy);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/washer_cycle_sequencer.md
WASHER_CYCLE_SEQUENCER -- requirements
Module: washer_cycle_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have ports wash_in, rinse_in, spin_in, cloth_in, input, 5 bits each: unsigned phase durations in ticks, taken from the appliance controller's washing-machine outputs.
REQ-004 SHALL have port tick, input, 1 bit: single-cycle time-base strobe, one per minute.
REQ-005 SHALL have ports start, pause, abort, input, 1 bit each: level-sampled commands.
REQ-006 SHALL have port phase, output, 3 bits: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DRAIN=5.
REQ-007 SHALL have port remaining, output, 8 bits: total ticks left in the cycle.
REQ-008 SHALL have ports water_valve, motor_on, drain_pump, busy, output, 1 bit each: actuator drives and cycle-active status.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse on normal cycle completion.

Function
REQ-010 SHALL, in IDLE with start=1, abort=0 and any input nonzero, latch all four inputs and enter the first nonzero phase of FILL(cloth_in), WASH, RINSE, SPIN on the next edge.
REQ-011 SHALL ignore start when all four inputs are zero, and SHALL ignore start while busy=1.
REQ-012 SHALL, on each tick with pause=0, decrement the current phase counter and remaining by 1.
REQ-013 SHALL, when a phase counter reaches 0, advance on that same edge to the next phase with nonzero duration, skipping zero-duration phases.
REQ-014 SHALL, on SPIN reaching 0, return to IDLE and assert done for exactly one cycle.
REQ-015 SHALL compute remaining as the 8-bit sum of the latched durations (max 124, no overflow) at start.
REQ-016 SHALL drive actuators as: FILL valve; WASH motor; RINSE motor+valve; SPIN motor+pump; DRAIN pump; IDLE none.
REQ-017 SHALL, while pause=1, freeze counters and phase and force water_valve=0 and motor_on=0; drain_pump follows the phase.
REQ-018 SHALL, on abort=1 in any non-IDLE, non-DRAIN phase, enter DRAIN for DRAIN_TICKS=2 ticks, set remaining=2, then enter IDLE with no done pulse.
REQ-019 SHALL give priority abort > pause > tick; tick and pause in the same cycle produce no decrement.
REQ-020 SHALL ignore abort in IDLE and DRAIN; pause SHALL NOT freeze DRAIN.
REQ-021 SHALL assert busy=1 in every phase except IDLE.

Reset
REQ-022 SHALL, on rst_n=0 at any time (including mid-cycle), force phase=IDLE, remaining=0, all actuators=0, busy=0, done=0, and clear latched durations.
REQ-023 SHALL require a fresh start after reset release; no cycle resumes.

Configuration
REQ-024 SHALL, with WASHER_DOOR_LOCK_EN defined, add input door_closed and output door_lock (=busy), ignore start while door_closed=0, and treat door_closed=0 while busy as pause=1.
REQ-025 SHALL, without WASHER_DOOR_LOCK_EN, omit door_closed and door_lock entirely, with behaviour otherwise identical.

Structure
REQ-026 SHALL take the phase encoding and DRAIN_TICKS from the shared appliance_pkg package.
REQ-027 SHALL instantiate one sub-module, phase_timer: a 5-bit loadable down-counter with tick enable and a zero flag.

Verification
REQ-028 SHALL be verified as follows: wash=7, rinse=13, spin=12, cloth=2, start -> phase 1 next cycle, remaining=34, then FILL 2 ticks, WASH 7, RINSE 13, SPIN 12, done pulse once, phase=0.
REQ-029 SHALL be verified as follows: cloth=0, wash=0, rinse=3, spin=0, start -> RINSE directly, 3 ticks, done, with no FILL, WASH or SPIN.
REQ-030 SHALL be verified as follows: all inputs 0, start -> phase stays 0, busy=0.
REQ-031 SHALL be verified as follows: pause held 5 ticks mid-WASH -> remaining is unchanged and motor_on=0; on release the countdown resumes from the same value.
REQ-032 SHALL be verified as follows: abort asserted with start in RINSE -> DRAIN, pump=1, remaining=2, IDLE after 2 ticks, no done.
REQ-033 SHALL be verified as follows: rst_n low mid-SPIN -> all outputs 0 immediately, without waiting for clk.
